inst_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of `inst_cache`. Holds the fetch PC, drives the cache's `ptr`/`inst_get` request pair, and captures each returned word into a small prefetch queue together with its PC. It presents instructions to decode with a valid/accept handshake. A one-cycle redirect from execute flushes the queue and restarts fetch at a new PC.

---
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: cache request/response pair, execute redirect, and decode handshake.
interface inst_fetch_if #(
  parameter int unsigned WORD_SIZE = 32
) ();
  logic [WORD_SIZE-1:0] ic_ptr;
  logic                 ic_get;
  logic [WORD_SIZE-1:0] ic_data;
  logic                 ic_ready;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic [WORD_SIZE-1:0] inst_out;
  logic [WORD_SIZE-1:0] inst_pc;
  logic                 inst_valid;
  logic                 inst_accept;

  modport master (
    output ic_ptr, ic_get, inst_out, inst_pc, inst_valid,
    input  ic_data, ic_ready, redirect, redirect_pc, inst_accept
  );

  modport slave (
    input  ic_ptr, ic_get, inst_out, inst_pc, inst_valid,
    output ic_data, ic_ready, redirect, redirect_pc, inst_accept
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: issues one-at-a-time cache requests, buffers returned words with
// their PCs in a small prefetch queue, and flushes/restarts fetch on redirect.
module inst_fetch_unit #(
  parameter int unsigned            WORD_SIZE   = 32,
  parameter logic [WORD_SIZE-1:0]   RESET_PC    = '0,
  parameter int unsigned            QUEUE_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
);
  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] w_pc_next;
  logic [WORD_SIZE-1:0] r_ic_ptr;
  logic [WORD_SIZE-1:0] w_ic_ptr_next;
  logic                 r_ic_get;
  logic                 w_ic_get_next;

  logic [WORD_SIZE-1:0] r_q_data [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] r_q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     w_rd_next;
  logic [PTR_W-1:0]     w_wr_next;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_next;
  logic [CNT_W-1:0]     w_remain;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_space;

  logic                 r_inst_valid;
  logic [WORD_SIZE-1:0] r_inst_out;
  logic [WORD_SIZE-1:0] r_inst_pc;
  logic [WORD_SIZE-1:0] w_head_data;
  logic [WORD_SIZE-1:0] w_head_pc;

  // Queue occupancy; redirect wipes the queue and overrides any pop or push.
  always_comb begin
    w_push   = (r_state == S_REQ) && bus.ic_ready && !bus.redirect;
    w_pop    = r_inst_valid && bus.inst_accept && !bus.redirect;
    w_remain = r_count - CNT_W'(w_pop);
    if (bus.redirect) begin
      w_count_next = '0;
      w_rd_next    = '0;
      w_wr_next    = '0;
    end else begin
      w_count_next = w_remain + CNT_W'(w_push);
      w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
      w_wr_next    = r_wr_ptr + PTR_W'(w_push);
    end
    w_space = (w_count_next < CNT_W'(QUEUE_DEPTH));
  end

  // Next head: an older surviving entry wins; otherwise a word pushed into an empty queue.
  always_comb begin
    w_head_data = r_inst_out;
    w_head_pc   = r_inst_pc;
    if (!bus.redirect) begin
      if (w_remain != '0) begin
        w_head_data = r_q_data[w_rd_next];
        w_head_pc   = r_q_pc[w_rd_next];
      end else if (w_push) begin
        w_head_data = bus.ic_data;
        w_head_pc   = r_ic_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Fetch control: the cache cannot abort, so a redirect while waiting parks in DRAIN.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      S_IDLE: begin
        if (bus.redirect) begin
          w_pc_next    = bus.redirect_pc;
          w_state_next = S_REQ;
        end else if (w_space) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.redirect) begin
          w_pc_next    = bus.redirect_pc;
          w_state_next = bus.ic_ready ? S_REQ : S_DRAIN;
        end else if (bus.ic_ready) begin
          w_pc_next    = r_pc + WORD_SIZE'(1);
          w_state_next = w_space ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.redirect) w_pc_next = bus.redirect_pc;
        if (bus.ic_ready) w_state_next = S_REQ;
      end
      default: w_state_next = S_IDLE;
    endcase
    w_ic_ptr_next = (w_state_next == S_REQ) ? w_pc_next : r_ic_ptr;
    w_ic_get_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ic_ptr     <= RESET_PC;
      r_ic_get     <= 1'b0;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_inst_valid <= 1'b0;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_pc         <= w_pc_next;
      r_ic_ptr     <= w_ic_ptr_next;
      r_ic_get     <= w_ic_get_next;
      r_count      <= w_count_next;
      r_rd_ptr     <= w_rd_next;
      r_wr_ptr     <= w_wr_next;
      r_inst_valid <= (w_count_next != '0);
      r_inst_out   <= w_head_data;
      r_inst_pc    <= w_head_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_q_data[r_wr_ptr] <= bus.ic_data;
      r_q_pc[r_wr_ptr]   <= r_ic_ptr;
    end
  end

  assign bus.ic_ptr     = r_ic_ptr;
  assign bus.ic_get     = r_ic_get;
  assign bus.inst_out   = r_inst_out;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.inst_valid = r_inst_valid;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: streaming, full queue, stalls, redirects, PC wrap, reset.
module tb_inst_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        use_tb_data;
  logic [31:0] tb_data;
  int          n_checks;
  int          n_fail;

  inst_fetch_if #(.WORD_SIZE(32)) bus ();

  inst_fetch_unit #(
    .WORD_SIZE  (32),
    .RESET_PC   (32'h0),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache stand-in: data is 0xA5000000 ^ address unless a specific word is forced.
  always_comb begin
    if (use_tb_data) bus.ic_data = tb_data;
    else             bus.ic_data = 32'hA500_0000 ^ bus.ic_ptr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_accept = 1'b0;
    bus.ic_ready    = 1'b0;
    use_tb_data     = 1'b0;
    tb_data         = 32'h0;
    rst_n           = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.ic_get !== 1'b0) begin n_fail++; $display("FAIL reset_ic_get: got %b expected 0", bus.ic_get); end
    n_checks++; if (bus.ic_ptr !== 32'h0) begin n_fail++; $display("FAIL reset_ic_ptr: got %h expected 00000000", bus.ic_ptr); end
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end
    n_checks++; if (bus.inst_out !== 32'h0) begin n_fail++; $display("FAIL reset_inst_out: got %h expected 00000000", bus.inst_out); end
    n_checks++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 00000000", bus.inst_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.ic_ready    = 1'b1;
    bus.inst_accept = 1'b1;
    tick();
    n_checks++; if (bus.ic_get !== 1'b1 || bus.ic_ptr !== 32'h0) begin n_fail++; $display("FAIL stream_first_req: got get=%b ptr=%h expected get=1 ptr=00000000", bus.ic_get, bus.ic_ptr); end
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle_ready_ignored: got valid=%b expected 0", bus.inst_valid); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.ic_ptr !== 32'(i + 1)) begin n_fail++; $display("FAIL stream_ptr[%0d]: got %h expected %h", i, bus.ic_ptr, 32'(i + 1)); end
      n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, bus.inst_valid, bus.inst_pc, 32'(i)); end
      n_checks++; if (bus.inst_out !== (32'hA500_0000 ^ 32'(i))) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, bus.inst_out, 32'hA500_0000 ^ 32'(i)); end
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.ic_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.ic_get !== 1'b1 || bus.ic_ptr !== 32'(i + 1)) begin n_fail++; $display("FAIL full_fill[%0d]: got get=%b ptr=%h expected get=1 ptr=%h", i, bus.ic_get, bus.ic_ptr, 32'(i + 1)); end
    end
    tick();
    n_checks++; if (bus.ic_get !== 1'b0) begin n_fail++; $display("FAIL full_get_drop: got %b expected 0", bus.ic_get); end
    tick();
    n_checks++; if (bus.ic_get !== 1'b0 || bus.inst_pc !== 32'h0 || bus.inst_out !== 32'hA500_0000) begin n_fail++; $display("FAIL full_hold: got get=%b pc=%h out=%h expected get=0 pc=00000000 out=a5000000", bus.ic_get, bus.inst_pc, bus.inst_out); end
    bus.inst_accept = 1'b1;
    tick();
    bus.inst_accept = 1'b0;
    n_checks++; if (bus.ic_get !== 1'b1 || bus.ic_ptr !== 32'h4) begin n_fail++; $display("FAIL full_resume: got get=%b ptr=%h expected get=1 ptr=00000004", bus.ic_get, bus.ic_ptr); end
    n_checks++; if (bus.inst_pc !== 32'h1 || bus.inst_out !== 32'hA500_0001) begin n_fail++; $display("FAIL full_pop_head: got pc=%h out=%h expected pc=00000001 out=a5000001", bus.inst_pc, bus.inst_out); end
    tick();
    n_checks++; if (bus.ic_get !== 1'b0) begin n_fail++; $display("FAIL full_refill_drop: got %b expected 0", bus.ic_get); end
    bus.ic_ready    = 1'b0;
    bus.inst_accept = 1'b1;
    for (int i = 2; i < 5; i++) begin
      tick();
      n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(i)) begin n_fail++; $display("FAIL full_drain[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, bus.inst_valid, bus.inst_pc, 32'(i)); end
    end
    tick();
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got valid=%b expected 0", bus.inst_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    bus.ic_ready = 1'b1;
    tick();
    bus.ic_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.ic_get !== 1'b1 || bus.ic_ptr !== 32'h1) begin n_fail++; $display("FAIL stall_hold[%0d]: got get=%b ptr=%h expected get=1 ptr=00000001", i, bus.ic_get, bus.ic_ptr); end
    end
    bus.ic_ready = 1'b1;
    tick();
    n_checks++; if (bus.ic_ptr !== 32'h2) begin n_fail++; $display("FAIL stall_advance: got ptr=%h expected 00000002", bus.ic_ptr); end
    bus.ic_ready    = 1'b0;
    bus.inst_accept = 1'b1;
    tick();
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h1 || bus.inst_out !== 32'hA500_0001) begin n_fail++; $display("FAIL stall_second: got valid=%b pc=%h out=%h expected valid=1 pc=00000001 out=a5000001", bus.inst_valid, bus.inst_pc, bus.inst_out); end
    tick();
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL stall_single_push: got valid=%b expected 0", bus.inst_valid); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    bus.ic_ready    = 1'b1;
    bus.inst_accept = 1'b1;
    tick();
    tick();
    tick();
    bus.ic_ready    = 1'b0;
    bus.inst_accept = 1'b0;
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    n_checks++; if (bus.inst_valid !== 1'b0 || bus.ic_ptr !== 32'h2 || bus.ic_get !== 1'b1) begin n_fail++; $display("FAIL drain_enter: got valid=%b ptr=%h get=%b expected valid=0 ptr=00000002 get=1", bus.inst_valid, bus.ic_ptr, bus.ic_get); end
    tick();
    n_checks++; if (bus.ic_ptr !== 32'h2) begin n_fail++; $display("FAIL drain_hold: got ptr=%h expected 00000002", bus.ic_ptr); end
    bus.ic_ready    = 1'b1;
    use_tb_data     = 1'b1;
    tb_data         = 32'h0000_DEAD;
    bus.inst_accept = 1'b1;
    tick();
    use_tb_data = 1'b0;
    n_checks++; if (bus.ic_ptr !== 32'h40 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_restart: got ptr=%h valid=%b expected ptr=00000040 valid=0", bus.ic_ptr, bus.inst_valid); end
    tick();
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40 || bus.inst_out !== 32'hA500_0040) begin n_fail++; $display("FAIL drain_first_out: got valid=%b pc=%h out=%h expected valid=1 pc=00000040 out=a5000040", bus.inst_valid, bus.inst_pc, bus.inst_out); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    bus.ic_ready    = 1'b1;
    bus.inst_accept = 1'b1;
    tick();
    tick();
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    n_checks++; if (bus.inst_valid !== 1'b0 || bus.ic_ptr !== 32'h100 || bus.ic_get !== 1'b1) begin n_fail++; $display("FAIL same_cycle_redirect: got valid=%b ptr=%h get=%b expected valid=0 ptr=00000100 get=1", bus.inst_valid, bus.ic_ptr, bus.ic_get); end
    tick();
    n_checks++; if (bus.inst_pc !== 32'h100 || bus.inst_out !== 32'hA500_0100 || bus.ic_ptr !== 32'h101) begin n_fail++; $display("FAIL same_cycle_next: got pc=%h out=%h ptr=%h expected pc=00000100 out=a5000100 ptr=00000101", bus.inst_pc, bus.inst_out, bus.ic_ptr); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    bus.ic_ready    = 1'b1;
    bus.inst_accept = 1'b1;
    tick();
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    n_checks++; if (bus.ic_ptr !== 32'hFFFF_FFFF || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_target: got ptr=%h valid=%b expected ptr=ffffffff valid=0", bus.ic_ptr, bus.inst_valid); end
    tick();
    n_checks++; if (bus.ic_ptr !== 32'h0 || bus.inst_pc !== 32'hFFFF_FFFF || bus.inst_out !== 32'h5AFF_FFFF) begin n_fail++; $display("FAIL wrap_step1: got ptr=%h pc=%h out=%h expected ptr=00000000 pc=ffffffff out=5affffff", bus.ic_ptr, bus.inst_pc, bus.inst_out); end
    tick();
    n_checks++; if (bus.ic_ptr !== 32'h1 || bus.inst_pc !== 32'h0 || bus.inst_out !== 32'hA500_0000) begin n_fail++; $display("FAIL wrap_step2: got ptr=%h pc=%h out=%h expected ptr=00000001 pc=00000000 out=a5000000", bus.ic_ptr, bus.inst_pc, bus.inst_out); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.ic_get !== 1'b0 || bus.ic_ptr !== 32'h0 || bus.inst_valid !== 1'b0 || bus.inst_out !== 32'h0 || bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL midreq_reset: got get=%b ptr=%h valid=%b out=%h pc=%h expected all zero", bus.ic_get, bus.ic_ptr, bus.inst_valid, bus.inst_out, bus.inst_pc); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.inst_valid !== 1'b0 || bus.ic_ptr !== 32'h0 || bus.ic_get !== 1'b1) begin n_fail++; $display("FAIL late_ready_ignored: got valid=%b ptr=%h get=%b expected valid=0 ptr=00000000 get=1", bus.inst_valid, bus.ic_ptr, bus.ic_get); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stream();
    test_full();
    test_stall();
    test_redirect_drain();
    test_redirect_same_cycle();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
